// File: rtl/param_shift_engine_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : param_shift_engine_if                                          |
// | Purpose  : Command / data / status bundle between a control FSM and the   |
// |            param_shift_engine data register.                              |
// | Signals  : cmd[2:0], cmd_valid, cmd_ready, shamt, d, sin, abort,          |
// |            q, sout, sout_valid, busy, done                                |
// | Modports : master - command issuer (drives cmd/shamt/d/sin/abort)         |
// |            slave  - the engine (drives q/sout/status)                     |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface param_shift_engine_if #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
);
  logic [2:0]         cmd;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   d;
  logic               sin;
  logic               abort;
  logic [WIDTH-1:0]   q;
  logic               sout;
  logic               sout_valid;
  logic               busy;
  logic               done;

  modport master (
    output cmd, cmd_valid, shamt, d, sin, abort,
    input  cmd_ready, q, sout, sout_valid, busy, done
  );

  modport slave (
    input  cmd, cmd_valid, shamt, d, sin, abort,
    output cmd_ready, q, sout, sout_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/param_shift_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : param_shift_engine                                             |
// | Purpose  : WIDTH-bit data register with command-per-operation semantics:  |
// |            single-cycle load / barrel shift / rotate, and multi-cycle     |
// |            MSB-first serial-out and serial-in transfers with abort.       |
// | Ports    : clk    - rising-edge clock                                     |
// |            res_n  - asynchronous active-low reset                         |
// |            bus    - param_shift_engine_if.slave (command, data, status)   |
// | Opcodes  : 000 LOAD, 001 SHL, 010 SHR, 011 ASR, 100 ROL, 101 ROR,         |
// |            110 SER_OUT, 111 SER_IN                                        |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module param_shift_engine #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = $clog2(WIDTH + 1)
) (
  input  wire logic            clk,
  input  wire logic            res_n,
  param_shift_engine_if.slave  bus
);

  localparam logic [2:0] OP_LOAD    = 3'b000;
  localparam logic [2:0] OP_SHL     = 3'b001;
  localparam logic [2:0] OP_SHR     = 3'b010;
  localparam logic [2:0] OP_ASR     = 3'b011;
  localparam logic [2:0] OP_ROL     = 3'b100;
  localparam logic [2:0] OP_ROR     = 3'b101;
  localparam logic [2:0] OP_SER_OUT = 3'b110;
  localparam logic [2:0] OP_SER_IN  = 3'b111;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SER_OUT = 2'd1,
    ST_SER_IN  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   w_q_nxt;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   w_count_nxt;
  logic               r_done;
  logic               w_done_nxt;

  // Barrel-shift datapath, evaluated every cycle from the current register.
  logic [SHAMT_W-1:0]   w_rot_amt;
  logic [2*WIDTH-1:0]   w_rol_full;
  logic [2*WIDTH-1:0]   w_ror_full;
  logic [WIDTH-1:0]     w_shl;
  logic [WIDTH-1:0]     w_shr;
  logic [WIDTH-1:0]     w_asr;

  // Rotation is modulo WIDTH; only matters for non-power-of-2 widths.
  assign w_rot_amt  = SHAMT_W'(32'(bus.shamt) % 32'(WIDTH));
  // Rotating the doubled word lets one shifter produce the wrapped bits.
  assign w_rol_full = {r_q, r_q} << w_rot_amt;
  assign w_ror_full = {r_q, r_q} >> w_rot_amt;
  // Shifts by >= WIDTH naturally yield all-zero / all-sign results.
  assign w_shl      = r_q << bus.shamt;
  assign w_shr      = r_q >> bus.shamt;
  assign w_asr      = $unsigned($signed(r_q) >>> bus.shamt);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd)
            OP_LOAD: begin w_q_nxt = bus.d;                      w_done_nxt = 1'b1; end
            OP_SHL:  begin w_q_nxt = w_shl;                      w_done_nxt = 1'b1; end
            OP_SHR:  begin w_q_nxt = w_shr;                      w_done_nxt = 1'b1; end
            OP_ASR:  begin w_q_nxt = w_asr;                      w_done_nxt = 1'b1; end
            OP_ROL:  begin w_q_nxt = w_rol_full[2*WIDTH-1:WIDTH]; w_done_nxt = 1'b1; end
            OP_ROR:  begin w_q_nxt = w_ror_full[WIDTH-1:0];      w_done_nxt = 1'b1; end
            OP_SER_OUT: begin
              w_state_nxt = ST_SER_OUT;
              w_count_nxt = '0;
            end
            OP_SER_IN: begin
              w_state_nxt = ST_SER_IN;
              w_count_nxt = '0;
            end
            default: ;
          endcase
        end
      end
      ST_SER_OUT, ST_SER_IN: begin
        // The shift for this cycle happens even when aborting.
        if (r_state == ST_SER_OUT) begin
          w_q_nxt = {r_q[WIDTH-2:0], 1'b0};
        end else begin
          w_q_nxt = {r_q[WIDTH-2:0], bus.sin};
        end
        if (bus.abort) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end else if (r_count == LAST_CNT) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign bus.q          = r_q;
  assign bus.done       = r_done;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.cmd_ready  = (r_state == ST_IDLE);
  assign bus.sout_valid = (r_state == ST_SER_OUT);
  assign bus.sout       = (r_state == ST_SER_OUT) ? r_q[WIDTH-1] : 1'b0;

endmodule
`default_nettype wire

// File: doc/param_shift_engine.md
Name: param_shift_engine

Overview:
- Parametrised successor to the team's 16-bit universal shift register.
- WIDTH-bit data register driven by a command interface with valid/ready handshake.
- Single-cycle parallel load, and barrel shifts/rotates by a variable amount (logical, arithmetic, rotate).
- Multi-cycle serial-out and serial-in transfers, with busy/done status and abort.
- Sits between a control FSM and a serial link; replaces mode-held shifting with command-per-operation semantics.

Parameters:
- WIDTH, 16, data register width in bits (>=2).
- SHAMT_W, $clog2(WIDTH), width of the shift-amount input.
- CNT_W, $clog2(WIDTH+1), width of the serial bit counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- res_n  input  1  asynchronous active-low reset.
- cmd  input  3  opcode: 000 LOAD, 001 SHL, 010 SHR, 011 ASR, 100 ROL, 101 ROR, 110 SER_OUT, 111 SER_IN.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  = !busy; a command is accepted when cmd_valid && cmd_ready.
- shamt  input  SHAMT_W  shift/rotate amount, sampled at acceptance.
- d  input  WIDTH  parallel load data, sampled at acceptance.
- sin  input  1  serial input bit.
- abort  input  1  synchronous cancel of a serial transfer.
- q  output  WIDTH  data register, continuously visible.
- sout  output  1  serial output bit: q[WIDTH-1] in SER_OUT, else 0.
- sout_valid  output  1  high in every SER_OUT cycle.
- busy  output  1  high in SER_OUT/SER_IN states.
- done  output  1  one-cycle registered pulse on command completion.

Behaviour:
- Reset (async, res_n low): q=0, state=IDLE, count=0, done=0. busy, sout and sout_valid are therefore 0. Reset mid-transfer aborts immediately; no done.
- FSM states: IDLE, SER_OUT, SER_IN.
  - IDLE: accepts commands.
  - cmd_valid with busy=1: ignored, no side effect, no queueing.
- Single-cycle ops, accepted in IDLE; q is updated at the accepting edge, done=1 for the following cycle only.
  - LOAD: q<=d.
  - SHL: q<<shamt, zero fill.
  - SHR: q>>shamt, zero fill.
  - ASR: arithmetic right shift, fill with q[WIDTH-1].
  - ROL/ROR: rotate by shamt mod WIDTH.
  - shamt=0: q unchanged, done still pulses.
  - shamt>=WIDTH (only possible for non-power-of-2 WIDTH): SHL/SHR give 0; ASR gives all bits = old sign bit.
- SER_OUT: acceptance moves to SER_OUT with count=0, q unchanged at the accepting edge.
  - Each SER_OUT cycle: sout=q[WIDTH-1], sout_valid=1, q<=q<<1, count++. MSB first, exactly WIDTH cycles.
  - After the WIDTH-th cycle: IDLE; q=0; done=1 in the first IDLE cycle.
- SER_IN: acceptance moves to SER_IN, count=0.
  - Each SER_IN cycle: q<={q[WIDTH-2:0],sin}, count++. The first sampled bit ends at MSB.
  - After WIDTH cycles: IDLE, done pulse. sout_valid stays 0.
- abort: in SER_OUT/SER_IN, if high at an edge, that cycle's shift still occurs, then IDLE.
  - No done pulse; q keeps the partial value; count reset.
  - abort in IDLE is ignored.
- A new command may be accepted in the same cycle done is high (back-to-back allowed); cmd_ready is 1 then.
- All outputs except sout/sout_valid/busy/cmd_ready are registered. Those four decode the state combinationally.

Test Plan:
- WIDTH=16. LOAD 0xA5C3, then ROL shamt=4 -> q=0xA5C3 then 0x5C3A; done high exactly one cycle after each acceptance.
- LOAD 0x8001; ASR shamt=3 -> q=0xF000; LOAD 0x8001; SHR shamt=3 -> q=0x1000; SHL shamt=0 -> unchanged, done pulses.
- LOAD 0xA5C3; SER_OUT -> sout over 16 cycles = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 with sout_valid=busy=1; final q=0x0000 and one done pulse. A LOAD 0xFFFF with cmd_valid at cycle 8 is ignored.
- SER_IN with sin=1 on the first cycle, then 0 for 15 cycles -> q=0x8000, done pulse, sout_valid stays 0.
- LOAD 0xA5C3; SER_OUT; abort high on the 5th SER_OUT cycle -> q=0xB860, state IDLE, no done, cmd_ready=1 next cycle.
- Assert res_n=0 mid SER_IN (cycle 7) -> q, busy, done, sout_valid go 0 immediately without a clock; after release, LOAD works normally.
